// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the LED debug probe:
//   - dbg_mode_e     : display mode encodings driven from the board switches
//   - DBG_SEL_PORT_W : width of the channel-select switch field
//   - dbg_sel_w()    : channel index width derived from the channel count
//   - dbg_slice_lo() : low bit of channel k inside a flattened probe bus
// -----------------------------------------------------------------------------
package dbg_pkg;

  typedef enum logic [1:0] {
    DBG_LIVE   = 2'b00,
    DBG_SNAP   = 2'b01,
    DBG_SCAN   = 2'b10,
    DBG_STICKY = 2'b11
  } dbg_mode_e;

  // The select field comes from switches [15:8].
  localparam int unsigned DBG_SEL_PORT_W = 8;

  // A single-channel probe still needs a 1-bit index to keep port widths legal.
  function automatic int unsigned dbg_sel_w(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Channel k occupies bus[k*width +: width].
  function automatic int unsigned dbg_slice_lo(input int unsigned ch,
                                               input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/dbg_scan_timer.sv
// -----------------------------------------------------------------------------
// dbg_scan_timer
// Auto-scan sequencer for dbg_led_probe (only built with DBG_PROBE_SCAN_EN).
// A divider counts 0..SCAN_DIV-1; on its terminal count the channel counter
// steps and wraps from CHANNELS-1 back to 0. restart forces both to 0 and
// takes priority over counting.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active low
//   enable   in   count while high, hold while low
//   restart  in   synchronous restart of divider and channel counter
//   scan_ch  out  current scan channel
// -----------------------------------------------------------------------------
module dbg_scan_timer #(
  parameter int unsigned CHANNELS = 64,
  parameter int unsigned SCAN_DIV = 12_500_000,
  parameter int unsigned SEL_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  output logic [SEL_W-1:0] scan_ch
);

  localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

  logic [DIV_W-1:0] div_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      scan_ch <= '0;
    end else if (restart) begin
      div_cnt <= '0;
      scan_ch <= '0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        scan_ch <= (scan_ch == CH_LAST) ? '0 : scan_ch + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbg_led_probe.sv
// -----------------------------------------------------------------------------
// dbg_led_probe
// Debug probe for the board LED bank. Selects one WIDTH-bit word out of
// CHANNELS probe words and drives it, registered, onto the LEDs.
//   mode 00 LIVE   : probe[sel]
//   mode 01 SNAP   : whole bus frozen on a trig rising edge, browse with sel
//   mode 10 SCAN   : auto-step through channels every SCAN_DIV cycles
//   mode 11 STICKY : OR-accumulate probe[sel]; cleared by trig edge, sel
//                    change or entry into STICKY
// When sel >= CHANNELS the passthru word is shown (not in SCAN).
//
// Build option: define DBG_PROBE_SCAN_EN to build the SCAN sequencer. Without
// it, mode 10 behaves as LIVE and cur_ch always tracks sel.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   probe_bus  in   CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   sel        in   channel select (switches [15:8])
//   mode       in   display mode (dbg_mode_e encoding)
//   trig       in   debounced button level, rising edge is the event
//   passthru   in   word shown when sel is out of range
//   led_data   out  registered display word
//   cur_ch     out  channel currently displayed
//   frozen     out  snapshot holds captured data
// -----------------------------------------------------------------------------
module dbg_led_probe
  import dbg_pkg::*;
#(
  parameter  int unsigned CHANNELS = 64,
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned SCAN_DIV = 12_500_000,
  localparam int unsigned SEL_W    = dbg_sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] probe_bus,
  input  logic [DBG_SEL_PORT_W-1:0] sel,
  input  logic [1:0]                mode,
  input  logic                      trig,
  input  logic [WIDTH-1:0]          passthru,
  output logic [WIDTH-1:0]          led_data,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      frozen
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                      trig_q;
  dbg_mode_e                 mode_q;
  logic [DBG_SEL_PORT_W-1:0] sel_q;
  logic [CHANNELS*WIDTH-1:0] snap;
  logic [WIDTH-1:0]          acc;
  logic [SEL_W-1:0]          cur_ch_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  dbg_mode_e        mode_e;
  dbg_mode_e        eff_mode;
  logic             trig_edge;
  logic             in_range;
  logic [SEL_W-1:0] sel_idx;
  logic             sticky_clr;

  assign mode_e    = dbg_mode_e'(mode);
  assign trig_edge = trig & ~trig_q;
  assign in_range  = (32'(sel) < CHANNELS);
  assign sel_idx   = sel[SEL_W-1:0];

  // A trig edge, a new sel and entry into STICKY all collapse into one clear.
  assign sticky_clr = trig_edge | (sel != sel_q) | (mode_q != DBG_STICKY);

`ifdef DBG_PROBE_SCAN_EN
  assign eff_mode = mode_e;
`else
  assign eff_mode = (mode_e == DBG_SCAN) ? DBG_LIVE : mode_e;
`endif

  // ---------------------------------------------------------------------------
  // Word selection from the live bus and from the snapshot
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] live_word;
  logic [WIDTH-1:0] snap_word;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    live_word = '0;
    snap_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_idx == SEL_W'(k)) begin
        live_word = probe_bus[dbg_slice_lo(k, WIDTH) +: WIDTH];
        snap_word = snap[dbg_slice_lo(k, WIDTH) +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-scan
  // ---------------------------------------------------------------------------
`ifdef DBG_PROBE_SCAN_EN
  logic             scan_enable;
  logic             scan_restart;
  logic [SEL_W-1:0] scan_ch;
  logic [SEL_W-1:0] scan_sel;
  logic [WIDTH-1:0] scan_word;

  assign scan_enable  = (mode_e == DBG_SCAN);
  assign scan_restart = (mode_e == DBG_SCAN) && (mode_q != DBG_SCAN);
  // On the entry edge the counter is being forced to 0, so display channel 0.
  assign scan_sel     = scan_restart ? '0 : scan_ch;

  dbg_scan_timer #(
    .CHANNELS (CHANNELS),
    .SCAN_DIV (SCAN_DIV),
    .SEL_W    (SEL_W)
  ) u_scan_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (scan_enable),
    .restart (scan_restart),
    .scan_ch (scan_ch)
  );

  always_comb begin
    scan_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (scan_sel == SEL_W'(k)) begin
        scan_word = probe_bus[dbg_slice_lo(k, WIDTH) +: WIDTH];
      end
    end
  end

  // In SCAN the counter itself is reported; led_data trails it by one cycle.
  assign cur_ch = (mode_q == DBG_SCAN) ? scan_ch : cur_ch_q;
`else
  assign cur_ch = cur_ch_q;
`endif

  // ---------------------------------------------------------------------------
  // Next display word, accumulator and channel
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] led_next;
  logic [WIDTH-1:0] acc_next;
  logic [SEL_W-1:0] cur_next;

  always_comb begin
    led_next = in_range ? live_word : passthru;
    acc_next = acc;
    cur_next = sel_idx;
    case (eff_mode)
      DBG_SNAP: begin
        led_next = in_range ? snap_word : passthru;
      end
`ifdef DBG_PROBE_SCAN_EN
      DBG_SCAN: begin
        led_next = scan_word;
        cur_next = scan_sel;
      end
`endif
      DBG_STICKY: begin
        if (in_range) begin
          acc_next = sticky_clr ? live_word : (acc | live_word);
          led_next = acc_next;
        end else begin
          led_next = passthru;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: snap is a flop bank rather than a RAM, so it is reset with the rest
  // of the state; a browse before the first capture then shows zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_q   <= 1'b1;    // a button held through reset is not an edge
      mode_q   <= DBG_LIVE;
      sel_q    <= '0;
      snap     <= '0;
      frozen   <= 1'b0;
      acc      <= '0;
      led_data <= '0;
      cur_ch_q <= '0;
    end else begin
      trig_q   <= trig;
      mode_q   <= mode_e;
      sel_q    <= sel;
      acc      <= acc_next;
      led_data <= led_next;
      cur_ch_q <= cur_next;
      if ((eff_mode == DBG_SNAP) && trig_edge) begin
        snap   <= probe_bus;
        frozen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dbg_led_probe.sv
// -----------------------------------------------------------------------------
// tb_dbg_led_probe
// Directed bench for dbg_led_probe with CHANNELS=4, WIDTH=16, SCAN_DIV=3.
// Inputs change 1 time unit after a rising edge; outputs are compared at the
// same point, so each comparison sees the result of the edge just taken.
// Works with and without DBG_PROBE_SCAN_EN.
// -----------------------------------------------------------------------------
module tb_dbg_led_probe;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned SCAN_DIV = 3;

  logic                      clk;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] probe_bus;
  logic [7:0]                sel;
  logic [1:0]                mode;
  logic                      trig;
  logic [WIDTH-1:0]          passthru;
  logic [WIDTH-1:0]          led_data;
  logic [1:0]                cur_ch;
  logic                      frozen;

  int n_vec;
  int n_err;

  dbg_led_probe #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .probe_bus (probe_bus),
    .sel       (sel),
    .mode      (mode),
    .trig      (trig),
    .passthru  (passthru),
    .led_data  (led_data),
    .cur_ch    (cur_ch),
    .frozen    (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    probe_bus = '0; sel = '0; mode = 2'b00; trig = 1'b0; passthru = '0;
    tick(2);
    n_vec++;
    if (led_data !== 16'h0000 || cur_ch !== 2'd0 || frozen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state led=%h cur_ch=%0d frozen=%b expected 0000/0/0",
               led_data, cur_ch, frozen);
    end
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_live;
    probe_bus = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    mode = 2'b00; sel = 8'd2;
    tick(1);
    n_vec++;
    if (led_data !== 16'hCCCC || cur_ch !== 2'd2) begin
      n_err++;
      $display("FAIL live_sel2 led=%h cur_ch=%0d expected CCCC/2", led_data, cur_ch);
    end
    sel = 8'd9; passthru = 16'h1234;
    tick(1);
    n_vec++;
    if (led_data !== 16'h1234 || cur_ch !== 2'd1) begin
      n_err++;
      $display("FAIL live_passthru led=%h cur_ch=%0d expected 1234/1", led_data, cur_ch);
    end
    // One-cycle latency: old word until the next edge.
    sel = 8'd3;
    #2;
    n_vec++;
    if (led_data !== 16'h1234) begin
      n_err++;
      $display("FAIL live_latency_hold led=%h expected 1234", led_data);
    end
    tick(1);
    n_vec++;
    if (led_data !== 16'hDDDD) begin
      n_err++;
      $display("FAIL live_sel3 led=%h expected DDDD", led_data);
    end
  endtask

  task automatic test_snap;
    probe_bus[16 +: 16] = 16'h0011;
    sel = 8'd1; mode = 2'b01;
    tick(1);
    n_vec++;
    if (led_data !== 16'h0000 || frozen !== 1'b0) begin
      n_err++;
      $display("FAIL snap_before_trig led=%h frozen=%b expected 0000/0", led_data, frozen);
    end
    trig = 1'b1;
    tick(1);
    n_vec++;
    if (led_data !== 16'h0000 || frozen !== 1'b1) begin
      n_err++;
      $display("FAIL snap_capture_edge led=%h frozen=%b expected 0000/1", led_data, frozen);
    end
    trig = 1'b0; probe_bus[16 +: 16] = 16'hFFFF;
    tick(2);
    n_vec++;
    if (led_data !== 16'h0011 || frozen !== 1'b1) begin
      n_err++;
      $display("FAIL snap_frozen_ch1 led=%h frozen=%b expected 0011/1", led_data, frozen);
    end
    sel = 8'd0;
    tick(1);
    n_vec++;
    if (led_data !== 16'hAAAA) begin
      n_err++;
      $display("FAIL snap_browse_ch0 led=%h expected AAAA", led_data);
    end
    sel = 8'd1; trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(1);
    n_vec++;
    if (led_data !== 16'hFFFF) begin
      n_err++;
      $display("FAIL snap_recapture led=%h expected FFFF", led_data);
    end
  endtask

  task automatic test_scan;
    logic [15:0] words [4];
    int          exp_ch;
    int          prev_ch;
    words = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    probe_bus = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
`ifdef DBG_PROBE_SCAN_EN
    sel = 8'd9; passthru = 16'h1234; mode = 2'b10;
    for (int i = 0; i < 13; i++) begin
      tick(1);
      exp_ch  = (i / SCAN_DIV) % CHANNELS;
      prev_ch = (i == 0) ? 0 : ((i - 1) / SCAN_DIV) % CHANNELS;
      n_vec++;
      if (cur_ch !== 2'(exp_ch) || led_data !== words[prev_ch]) begin
        n_err++;
        $display("FAIL scan_step%0d cur_ch=%0d led=%h expected %0d/%h",
                 i, cur_ch, led_data, exp_ch, words[prev_ch]);
      end
    end
`else
    sel = 8'd2; mode = 2'b10;
    tick(1);
    n_vec++;
    if (led_data !== words[2] || cur_ch !== 2'd2) begin
      n_err++;
      $display("FAIL scan_as_live led=%h cur_ch=%0d expected CCCC/2", led_data, cur_ch);
    end
    sel = 8'd9; passthru = 16'h1234;
    tick(1);
    n_vec++;
    if (led_data !== 16'h1234 || cur_ch !== 2'd1) begin
      n_err++;
      $display("FAIL scan_as_live_pt led=%h cur_ch=%0d expected 1234/1", led_data, cur_ch);
    end
`endif
  endtask

  // Snapshot survives other modes, and edges outside SNAP do not capture.
  task automatic test_retain;
    mode = 2'b00; sel = 8'd1;
    probe_bus[16 +: 16] = 16'h5555;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(1);
    mode = 2'b01;
    tick(1);
    n_vec++;
    if (led_data !== 16'hFFFF || frozen !== 1'b1) begin
      n_err++;
      $display("FAIL snap_retained led=%h frozen=%b expected FFFF/1", led_data, frozen);
    end
  endtask

  task automatic test_sticky;
    logic [15:0] exp_seq [9];
    exp_seq = '{16'h0001, 16'h0101, 16'h0101, 16'h0000, 16'h0010,
                16'hAAAA, 16'hFFFF, 16'h1234, 16'h5555};
    probe_bus = {16'hDDDD, 16'hCCCC, 16'h0001, 16'hAAAA};
    passthru = 16'h1234;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin sel = 8'd1; mode = 2'b11; end
        1: probe_bus[16 +: 16] = 16'h0100;
        2: probe_bus[16 +: 16] = 16'h0000;
        3: trig = 1'b1;
        4: begin trig = 1'b0; probe_bus[16 +: 16] = 16'h0010; end
        5: sel = 8'd0;
        6: probe_bus[0 +: 16] = 16'h5555;
        7: sel = 8'd9;
        default: sel = 8'd0;
      endcase
      tick(1);
      n_vec++;
      if (led_data !== exp_seq[i]) begin
        n_err++;
        $display("FAIL sticky_step%0d led=%h expected %h", i, led_data, exp_seq[i]);
      end
    end
  endtask

  // Trig edge and sel change on the same cycle: one clear, no OR with old acc.
  task automatic test_back_to_back;
    probe_bus[32 +: 16] = 16'h0F0F;
    sel = 8'd2; trig = 1'b1;
    tick(1);
    n_vec++;
    if (led_data !== 16'h0F0F) begin
      n_err++;
      $display("FAIL same_cycle_clear led=%h expected 0F0F", led_data);
    end
    trig = 1'b0; probe_bus[32 +: 16] = 16'hF000;
    tick(1);
    n_vec++;
    if (led_data !== 16'hFF0F) begin
      n_err++;
      $display("FAIL same_cycle_accum led=%h expected FF0F", led_data);
    end
  endtask

  task automatic test_reset_mid;
    mode = 2'b01; sel = 8'd1;
    probe_bus[16 +: 16] = 16'h4242;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(1);
    n_vec++;
    if (led_data !== 16'h4242 || frozen !== 1'b1 || cur_ch !== 2'd1) begin
      n_err++;
      $display("FAIL pre_reset led=%h frozen=%b cur_ch=%0d expected 4242/1/1",
               led_data, frozen, cur_ch);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (led_data !== 16'h0000 || frozen !== 1'b0 || cur_ch !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset led=%h frozen=%b cur_ch=%0d expected 0000/0/0",
               led_data, frozen, cur_ch);
    end
    trig = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(3);
    n_vec++;
    if (led_data !== 16'h0000 || frozen !== 1'b0) begin
      n_err++;
      $display("FAIL held_trig_no_capture led=%h frozen=%b expected 0000/0", led_data, frozen);
    end
    trig = 1'b0;
    tick(1);
    trig = 1'b1;
    tick(1);
    n_vec++;
    if (led_data !== 16'h0000 || frozen !== 1'b1) begin
      n_err++;
      $display("FAIL rearm_capture led=%h frozen=%b expected 0000/1", led_data, frozen);
    end
    trig = 1'b0;
    tick(1);
    n_vec++;
    if (led_data !== 16'h4242) begin
      n_err++;
      $display("FAIL rearm_display led=%h expected 4242", led_data);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_live();
    test_snap();
    test_scan();
    test_retain();
    test_sticky();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dbg_led_probe.md
# dbg_led_probe

Parametrised debug probe for the board LED bank: selects one of `CHANNELS` probe words of `WIDTH` bits from a flattened bus and drives it, registered, onto `led_data`. Four modes: live view, whole-bus freeze snapshot on a trigger, optional auto-scan through channels, and sticky-bit accumulation. It sits at the top level between the CPU pipeline debug taps and the LED pins, replacing the fixed-case LED multiplexer.

## Interface
- `CHANNELS`, 64: number of probe words; `SEL_W = $clog2(CHANNELS)` is derived.
- `WIDTH`, 16: bits per probe word and LED width.
- `SCAN_DIV`, 12_500_000: clock cycles per channel step in SCAN mode; must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  active-low asynchronous reset.
- `probe_bus`  in  CHANNELS*WIDTH  channel k at `[k*WIDTH +: WIDTH]`.
- `sel`  in  8  channel select (board switches [15:8]).
- `mode`  in  2  00 LIVE, 01 SNAP, 10 SCAN, 11 STICKY.
- `trig`  in  1  debounced button level; rising edge is the event.
- `passthru`  in  WIDTH  shown when `sel ≥ CHANNELS` (board switches).
- `led_data`  out  WIDTH  registered display word.
- `cur_ch`  out  SEL_W  channel currently displayed.
- `frozen`  out  1  snapshot holds valid captured data.

## Operation
- Edge detect: `trig_q` <= `trig`. `edge = trig & ~trig_q`.
- LIVE: `led_data` <= `probe[sel]`, or `passthru` if `sel ≥ CHANNELS`. `cur_ch` <= `sel[SEL_W-1:0]`.
- SNAP:
  - On `edge`, the entire `probe_bus` is copied into `snap` and `frozen` is set to 1.
  - Each further edge recaptures.
  - `led_data` <= `snap[sel]` (or `passthru` if out of range). All channels can be browsed by changing `sel` while frozen.
  - `snap` and `frozen` are retained across mode changes. They are cleared only by reset.
- SCAN:
  - A divider counts 0..SCAN_DIV-1. At terminal count, `scan_ch` increments and wraps at CHANNELS-1 → 0.
  - On entry to SCAN (mode changes to 10), the divider and `scan_ch` restart at 0.
  - `led_data` <= `probe[scan_ch]`. `cur_ch = scan_ch`. `sel` and `passthru` are ignored.
- STICKY:
  - `acc` <= `clr ? probe[sel] : acc | probe[sel]`.
  - `clr` = `edge`, OR `sel` differs from the previous cycle, OR mode entry into STICKY.
  - `led_data` <= `acc` next value.
  - If `sel ≥ CHANNELS`, `acc` holds and `led_data` = `passthru`.
- Simultaneous events: any number of simultaneous clear causes clears once.
- `edge` in a non-SNAP mode does not capture.

## Timing
- Reset values: `led_data`=0, `cur_ch`=0, `frozen`=0, `snap`=0, `acc`=0, divider=0, `scan_ch`=0, `trig_q`=1 (a held button gives no edge after reset), `mode_q`=00, `sel_q`=0.
- Latency: `probe`/`sel` → `led_data` is 1 cycle.
- Latency: `trig` rise → `snap` updated at the sampling edge, visible on `led_data` 1 cycle later (2 edges total).
- SCAN step:
  - `scan_ch` advances exactly every SCAN_DIV cycles.
  - `led_data` follows 1 cycle after `scan_ch`.
  - With SCAN_DIV=1, it advances every cycle.
- Reset mid-operation clears everything immediately (async); operation resumes on the first clock after deassertion.

## Configuration
- `DBG_PROBE_SCAN_EN`:
  - Defined: SCAN mode, divider, and `scan_ch` are built.
  - Undefined: mode 10 behaves exactly as LIVE, no divider logic exists, and `cur_ch` always tracks `sel`.

## Structure
- Shared package `dbg_pkg`: mode encodings `DBG_LIVE`/`DBG_SNAP`/`DBG_SCAN`/`DBG_STICKY` and the probe-bus slice helper constant definitions.
- One sub-module `dbg_scan_timer`: the SCAN_DIV divider plus wrapping channel counter, with a restart input. It is instantiated only under `DBG_PROBE_SCAN_EN`.

## Test plan
Bench parameters: CHANNELS=4, WIDTH=16, SCAN_DIV=3.
- LIVE: probe = {ch3=0xDDDD, ch2=0xCCCC, ch1=0xBBBB, ch0=0xAAAA}, sel=2 → `led_data`=0xCCCC one cycle later. sel=9, passthru=0x1234 → 0x1234.
- SNAP: probe ch1=0x0011, mode=01, pulse trig, then change ch1 to 0xFFFF → `led_data` stays 0x0011 and `frozen`=1. sel=0 shows captured ch0. Second trig pulse → 0xFFFF.
- SCAN: enter mode 10 → `cur_ch` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; `led_data` tracks it 1 cycle late. Without the macro, `led_data` = `probe[sel]`.
- STICKY: sel=1, ch1 pulses 0x0001, then 0x0100, then 0x0000 → `led_data`=0x0101. Trig edge with ch1=0 → 0x0000. sel change to 0 → clears to `probe[0]`.
- Reset: assert `rst`=0 mid-SNAP with `frozen`=1 → all outputs 0 asynchronously. Deassert while trig held high → no capture until trig falls and rises again.
- Same-cycle events: in STICKY, trig edge and sel change together → a single clear, `acc` = new `probe[sel]`.
